// File: rtl/mem_stage_pkg.sv
// ============================================================================
// mem_stage_pkg : shared pipeline widths and field layout for the MEM stage
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_stage_pkg;

    localparam int EX_SIG_W = 7;
    localparam int WB_SIG_W = 6;
    localparam int XLEN     = 32;

    // Field order of the EX->MEM control bundle, MSB first.
    typedef struct packed {
        logic       res_from_mem;
        logic       gr_we;
        logic [4:0] dest;
    } ex_sig_t;

    typedef struct packed {
        logic       gr_we;
        logic [4:0] dest;
    } wb_sig_t;

    function automatic wb_sig_t to_wb_sig(input ex_sig_t s);
        wb_sig_t w;
        w.gr_we = s.gr_we;
        w.dest  = s.dest;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage : pipeline MEM stage with load-data buffering across WB stalls
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                EXU_to_MEM_valid,
    output logic                MEM_allow_in,
    input  logic                WB_allow_in,
    output logic                MEM_to_WB_valid,
    input  logic [XLEN-1:0]     EXU_pc_to_MEM,
    input  logic [XLEN-1:0]     EXU_inst_to_MEM,
    input  logic [XLEN-1:0]     EXU_alu_result_to_MEM,
    input  logic [EX_SIG_W-1:0] EXU_signals_pass_to_MEM,
    input  logic [XLEN-1:0]     data_sram_rdata,
    output logic [XLEN-1:0]     MEM_pc_to_WB,
    output logic [XLEN-1:0]     MEM_inst_to_WB,
    output logic [XLEN-1:0]     MEM_final_result_to_WB,
    output logic [WB_SIG_W-1:0] MEM_signals_to_WB,
    output logic                MEM_to_IDU_gr_we,
    output logic [4:0]          MEM_to_IDU_dest,
    output logic                MEM_to_IDU_valid,
    output logic [XLEN-1:0]     MEM_to_IDU_forward
);

    logic            mem_valid;
    logic            first_cycle;
    logic            buf_valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] alu_result;
    ex_sig_t         sigs;
    logic [XLEN-1:0] rdata_buf;

    logic            ready_go;
    logic            accept;
    logic            leave;
    logic            capture;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] final_result;

    assign ready_go     = 1'b1;
    assign MEM_allow_in = !mem_valid || (ready_go && WB_allow_in);
    assign accept       = MEM_allow_in && EXU_to_MEM_valid;
    assign leave        = mem_valid && ready_go && WB_allow_in;
    // SRAM data is only valid in the first MEM cycle; hold it if WB stalls us.
    assign capture      = mem_valid && first_cycle && sigs.res_from_mem && !WB_allow_in;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid   <= 1'b0;
            first_cycle <= 1'b0;
            pc          <= '0;
            inst        <= '0;
            alu_result  <= '0;
            sigs        <= '0;
        end else begin
            first_cycle <= accept;
            if (MEM_allow_in) begin
                mem_valid <= EXU_to_MEM_valid;
            end
            if (accept) begin
                pc         <= EXU_pc_to_MEM;
                inst       <= EXU_inst_to_MEM;
                alu_result <= EXU_alu_result_to_MEM;
                sigs       <= ex_sig_t'(EXU_signals_pass_to_MEM);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_valid <= 1'b0;
            rdata_buf <= '0;
        end else if (leave) begin
            buf_valid <= 1'b0;
        end else if (capture) begin
            buf_valid <= 1'b1;
            rdata_buf <= data_sram_rdata;
        end
    end

    assign load_data    = buf_valid ? rdata_buf : data_sram_rdata;
    assign final_result = sigs.res_from_mem ? load_data : alu_result;

    assign MEM_to_WB_valid        = mem_valid;
    assign MEM_pc_to_WB           = pc;
    assign MEM_inst_to_WB         = inst;
    assign MEM_final_result_to_WB = final_result;
    assign MEM_signals_to_WB      = to_wb_sig(sigs);
    assign MEM_to_IDU_gr_we       = sigs.gr_we;
    assign MEM_to_IDU_dest        = sigs.dest;
    assign MEM_to_IDU_valid       = mem_valid;
    assign MEM_to_IDU_forward     = final_result;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// tb_mem_stage : directed self-checking bench for mem_stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage;

    logic        clk;
    logic        resetn;
    logic        ex_valid;
    logic        allow_in;
    logic        wb_allow;
    logic        to_wb_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_inst;
    logic [31:0] ex_alu;
    logic [6:0]  ex_sigs;
    logic [31:0] rdata;
    logic [31:0] wb_pc;
    logic [31:0] wb_inst;
    logic [31:0] wb_result;
    logic [5:0]  wb_sigs;
    logic        idu_gr_we;
    logic [4:0]  idu_dest;
    logic        idu_valid;
    logic [31:0] idu_fwd;

    int n_vec = 0;
    int n_bad = 0;

    mem_stage dut (
        .clk                     (clk),
        .resetn                  (resetn),
        .EXU_to_MEM_valid        (ex_valid),
        .MEM_allow_in            (allow_in),
        .WB_allow_in             (wb_allow),
        .MEM_to_WB_valid         (to_wb_valid),
        .EXU_pc_to_MEM           (ex_pc),
        .EXU_inst_to_MEM         (ex_inst),
        .EXU_alu_result_to_MEM   (ex_alu),
        .EXU_signals_pass_to_MEM (ex_sigs),
        .data_sram_rdata         (rdata),
        .MEM_pc_to_WB            (wb_pc),
        .MEM_inst_to_WB          (wb_inst),
        .MEM_final_result_to_WB  (wb_result),
        .MEM_signals_to_WB       (wb_sigs),
        .MEM_to_IDU_gr_we        (idu_gr_we),
        .MEM_to_IDU_dest         (idu_dest),
        .MEM_to_IDU_valid        (idu_valid),
        .MEM_to_IDU_forward      (idu_fwd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [6:0] s);
        ex_valid = v;
        ex_pc    = pc;
        ex_inst  = pc ^ 32'h0000_0013;
        ex_alu   = alu;
        ex_sigs  = s;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"},    {31'd0, to_wb_valid}, 32'd0);
        chk({tag, "_allow"},    {31'd0, allow_in},    32'd1);
        chk({tag, "_idu_vld"},  {31'd0, idu_valid},   32'd0);
        chk({tag, "_pc"},       wb_pc,                32'd0);
        chk({tag, "_inst"},     wb_inst,              32'd0);
        chk({tag, "_result"},   wb_result,            32'd0);
        chk({tag, "_sigs"},     {26'd0, wb_sigs},     32'd0);
        chk({tag, "_fwd"},      idu_fwd,              32'd0);
        chk({tag, "_buf"},      {31'd0, dut.buf_valid}, 32'd0);
    endtask

    initial begin
        resetn   = 1'b0;
        wb_allow = 1'b1;
        rdata    = 32'h0;
        drive(1'b0, 32'h0, 32'h0, 7'h00);
        #12;
        chk_all_zero("reset");
        tick();
        resetn = 1'b1;

        // Load, WB ready: data visible the cycle after EX.
        drive(1'b1, 32'h0000_1000, 32'h0000_0100, 7'h63);
        tick();
        drive(1'b0, 32'h0, 32'h0, 7'h00);
        rdata = 32'hDEAD_BEEF;
        #1;
        chk("ld_valid",  {31'd0, to_wb_valid}, 32'd1);
        chk("ld_result", wb_result, 32'hDEAD_BEEF);
        chk("ld_pc",     wb_pc, 32'h0000_1000);
        chk("ld_inst",   wb_inst, 32'h0000_1013);
        chk("ld_sigs",   {26'd0, wb_sigs}, 32'h23);
        chk("ld_dest",   {27'd0, idu_dest}, 32'd3);
        chk("ld_gr_we",  {31'd0, idu_gr_we}, 32'd1);
        tick();
        chk("ld_gone",   {31'd0, to_wb_valid}, 32'd0);

        // Load stalled by WB for 3 cycles while SRAM data changes.
        wb_allow = 1'b0;
        drive(1'b1, 32'h0000_1004, 32'h0000_0104, 7'h64);
        tick();
        drive(1'b0, 32'h0, 32'h0, 7'h00);
        rdata = 32'hDEAD_BEEF;
        #1;
        chk("st0_result", wb_result, 32'hDEAD_BEEF);
        chk("st0_allow",  {31'd0, allow_in}, 32'd0);
        chk("st0_buf",    {31'd0, dut.buf_valid}, 32'd0);
        for (int i = 1; i < 3; i++) begin
            tick();
            rdata = 32'h1234_5678;
            #1;
            chk($sformatf("st%0d_result", i), wb_result, 32'hDEAD_BEEF);
            chk($sformatf("st%0d_allow", i),  {31'd0, allow_in}, 32'd0);
            chk($sformatf("st%0d_buf", i),    {31'd0, dut.buf_valid}, 32'd1);
            chk($sformatf("st%0d_valid", i),  {31'd0, to_wb_valid}, 32'd1);
        end
        tick();
        wb_allow = 1'b1;
        #1;
        chk("st_rel_allow",  {31'd0, allow_in}, 32'd1);
        chk("st_rel_result", wb_result, 32'hDEAD_BEEF);
        tick();
        chk("st_left_buf",   {31'd0, dut.buf_valid}, 32'd0);
        chk("st_left_valid", {31'd0, to_wb_valid}, 32'd0);

        // ALU op ignores SRAM data.
        drive(1'b1, 32'h0000_1008, 32'h0000_0042, 7'h25);
        tick();
        drive(1'b0, 32'h0, 32'h0, 7'h00);
        rdata = 32'hFFFF_FFFF;
        #1;
        chk("alu_result", wb_result, 32'h0000_0042);
        chk("alu_fwd",    idu_fwd, 32'h0000_0042);
        chk("alu_sigs",   {26'd0, wb_sigs}, 32'h25);
        tick();
        chk("alu_buf",    {31'd0, dut.buf_valid}, 32'd0);

        // Three back-to-back ALU ops, no bubbles.
        drive(1'b1, 32'h0000_2000, 32'h0000_0011, 7'h21);
        tick();
        drive(1'b1, 32'h0000_2004, 32'h0000_0022, 7'h22);
        #1;
        chk("b2b0_valid",  {31'd0, to_wb_valid}, 32'd1);
        chk("b2b0_pc",     wb_pc, 32'h0000_2000);
        chk("b2b0_result", wb_result, 32'h0000_0011);
        tick();
        drive(1'b1, 32'h0000_2008, 32'h0000_0033, 7'h23);
        #1;
        chk("b2b1_valid",  {31'd0, to_wb_valid}, 32'd1);
        chk("b2b1_pc",     wb_pc, 32'h0000_2004);
        chk("b2b1_result", wb_result, 32'h0000_0022);
        tick();
        drive(1'b0, 32'h0, 32'h0, 7'h00);
        #1;
        chk("b2b2_valid",  {31'd0, to_wb_valid}, 32'd1);
        chk("b2b2_pc",     wb_pc, 32'h0000_2008);
        chk("b2b2_result", wb_result, 32'h0000_0033);
        tick();
        chk("b2b_end",     {31'd0, to_wb_valid}, 32'd0);

        // Reset asserted mid-stall clears everything without a clock edge.
        wb_allow = 1'b0;
        drive(1'b1, 32'h0000_3000, 32'h0000_0300, 7'h66);
        tick();
        drive(1'b0, 32'h0, 32'h0, 7'h00);
        rdata = 32'hCAFE_0001;
        tick();
        rdata = 32'h0;
        #1;
        chk("rst_pre_buf", {31'd0, dut.buf_valid}, 32'd1);
        resetn = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        tick();
        resetn   = 1'b1;
        wb_allow = 1'b1;

        // Stalled load leaves while a new load is accepted in the same cycle.
        wb_allow = 1'b0;
        drive(1'b1, 32'h0000_4000, 32'h0000_0400, 7'h61);
        tick();
        drive(1'b0, 32'h0, 32'h0, 7'h00);
        rdata = 32'hAAAA_0001;
        tick();
        rdata = 32'h5555_5555;
        wb_allow = 1'b1;
        drive(1'b1, 32'h0000_4004, 32'h0000_0404, 7'h62);
        #1;
        chk("sw_old_result", wb_result, 32'hAAAA_0001);
        chk("sw_old_allow",  {31'd0, allow_in}, 32'd1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 7'h00);
        rdata = 32'hBBBB_0002;
        #1;
        chk("sw_new_result", wb_result, 32'hBBBB_0002);
        chk("sw_new_pc",     wb_pc, 32'h0000_4004);
        chk("sw_new_buf",    {31'd0, dut.buf_valid}, 32'd0);
        chk("sw_new_valid",  {31'd0, to_wb_valid}, 32'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
